// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the 5-stage pipeline hazard logic.
// Contents:
//   fwd_sel_e  - forward-select encodings for the E-stage ALU operand muxes
//   RW         - default register index width (32 architectural registers)
//   LONG_LAT   - default latency of the multi-cycle (mul/div) unit
//   SB_CNT_W   - width of the long-op scoreboard down-counter
package pipeline_pkg;

    // 00 selects the register file value, 01 the W-stage result, 10 the M-stage result.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int RW       = 5;
    localparam int LONG_LAT = 4;

    // The scoreboard counter is 8 bits wide, which bounds LONG_LAT to 255.
    localparam int SB_CNT_W = 8;

endpackage

// File: rtl/long_scoreboard.sv
// long_scoreboard
// Tracks the single in-flight operation of the multi-cycle execution unit.
// A down-counter is loaded with LONG_LAT on issue and counts down to zero;
// the unit is busy while the counter is non-zero and writes back in the
// cycle where the counter reads 1.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset; abandons any in-flight op
//   issue_i      in   a long op leaves decode at this cycle's closing edge
//   issue_reg_i  in   destination register of the issuing long op
//   long_busy_o  out  long unit occupied
//   long_done_o  out  long result is written at this cycle's closing edge
//   long_reg_o   out  destination of the in-flight (or most recent) long op
module long_scoreboard #(
    parameter int RW       = 5,
    parameter int LONG_LAT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          issue_i,
    input  logic [RW-1:0] issue_reg_i,
    output logic          long_busy_o,
    output logic          long_done_o,
    output logic [RW-1:0] long_reg_o
);
    import pipeline_pkg::*;

    localparam logic [SB_CNT_W-1:0] LAT_INIT = SB_CNT_W'(LONG_LAT);
    localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]       long_reg_q, long_reg_d;

    // Next-state: an issue reloads the counter and captures the destination;
    // otherwise the counter drains toward zero. Issue only happens while the
    // counter is zero because a busy unit structurally stalls the next long op.
    always_comb begin
        cnt_d      = cnt_q;
        long_reg_d = long_reg_q;
        if (issue_i) begin
            cnt_d      = LAT_INIT;
            long_reg_d = issue_reg_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Counter and destination registers, cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            long_reg_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            long_reg_q <= long_reg_d;
        end
    end

    // While reset is held the scoreboard is treated as idle, so a stale
    // counter value never produces a stall or a writeback strobe.
    assign long_busy_o = (cnt_q != '0) && !reset;
    assign long_done_o = (cnt_q == CNT_ONE) && !reset;
    assign long_reg_o  = long_reg_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard detection and forwarding controller for the 5-stage pipeline with
// one multi-cycle execution unit. Sits beside the datapath and drives the
// stall, flush and forward-select controls.
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   rs_d, rt_d, use_rs_d, use_rt_d  decode sources and whether they are read
//   valid_d, branch_d               decode holds a real instruction / a branch
//   reg_write_d, wr_reg_d           decode destination write
//   long_op_d                       decode instruction targets the long unit
//   rs_e, rt_e                      execute sources
//   wr_reg_e/m/w, reg_write_e/m/w   destinations and write enables in E/M/W
//   mem_to_reg_e, mem_to_reg_m      load in E / M
//   stall_f, stall_d, flush_e       hold PC, hold IF/ID, bubble into ID/EX
//   forward_a_e, forward_b_e        E operand selects (00 RF, 01 W, 10 M)
//   forward_a_d, forward_b_d        branch comparator takes the M result
//   long_busy, long_done, long_reg  long unit status
//   stall_count                     saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int RW       = $clog2(NREG),
    parameter int LONG_LAT = pipeline_pkg::LONG_LAT,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RW-1:0]    rs_d,
    input  logic [RW-1:0]    rt_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic             valid_d,
    input  logic             branch_d,
    input  logic             reg_write_d,
    input  logic [RW-1:0]    wr_reg_d,
    input  logic             long_op_d,
    input  logic [RW-1:0]    rs_e,
    input  logic [RW-1:0]    rt_e,
    input  logic [RW-1:0]    wr_reg_e,
    input  logic [RW-1:0]    wr_reg_m,
    input  logic [RW-1:0]    wr_reg_w,
    input  logic             reg_write_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             mem_to_reg_e,
    input  logic             mem_to_reg_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             forward_a_d,
    output logic             forward_b_d,
    output logic             long_busy,
    output logic             long_done,
    output logic [RW-1:0]    long_reg,
    output logic [CNT_W-1:0] stall_count
);
    import pipeline_pkg::*;

    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    // A writer in stage X feeds a consumer only if it writes, is not r0,
    // and targets the consumer's source register.
    function automatic logic writerHits(input logic wen, input logic [RW-1:0] dst,
                                        input logic [RW-1:0] src);
        return wen && (dst != '0) && (dst == src);
    endfunction

    // A decode source matches X only if it is actually read and X is not r0.
    function automatic logic decodeReads(input logic [RW-1:0] rsD, input logic useRs,
                                         input logic [RW-1:0] rtD, input logic useRt,
                                         input logic [RW-1:0] x);
        return (x != '0) && ((useRs && (rsD == x)) || (useRt && (rtD == x)));
    endfunction

    function automatic fwd_sel_e fwdSelect(input logic [RW-1:0] src,
                                           input logic wenM, input logic [RW-1:0] dstM,
                                           input logic wenW, input logic [RW-1:0] dstW);
        if (writerHits(wenM, dstM, src))
            return FWD_M;
        else if (writerHits(wenW, dstW, src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic lwStall, brStall, sbStall, stallAny, issueLong;
    logic [CNT_W-1:0] stall_count_q;

    long_scoreboard #(
        .RW       (RW),
        .LONG_LAT (LONG_LAT)
    ) u_long_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_i     (issueLong),
        .issue_reg_i (wr_reg_d),
        .long_busy_o (long_busy),
        .long_done_o (long_done),
        .long_reg_o  (long_reg)
    );

    assign forward_a_e = fwdSelect(rs_e, reg_write_m, wr_reg_m, reg_write_w, wr_reg_w);
    assign forward_b_e = fwdSelect(rt_e, reg_write_m, wr_reg_m, reg_write_w, wr_reg_w);
    assign forward_a_d = writerHits(reg_write_m, wr_reg_m, rs_d);
    assign forward_b_d = writerHits(reg_write_m, wr_reg_m, rt_d);

    // Load-use: the loaded value is not available until after M.
    assign lwStall = mem_to_reg_e && decodeReads(rs_d, use_rs_d, rt_d, use_rt_d, wr_reg_e);

    // Branches compare in D, so any E result or a load still in M must wait.
    assign brStall = branch_d &&
                     ((reg_write_e  && decodeReads(rs_d, use_rs_d, rt_d, use_rt_d, wr_reg_e)) ||
                      (mem_to_reg_m && decodeReads(rs_d, use_rs_d, rt_d, use_rt_d, wr_reg_m)));

    // Long results are never forwarded, so RAW, WAW and a second long op all
    // wait until the unit drains.
    assign sbStall = valid_d && long_busy &&
                     (decodeReads(rs_d, use_rs_d, rt_d, use_rt_d, long_reg) ||
                      (reg_write_d && (long_reg != '0) && (wr_reg_d == long_reg)) ||
                      long_op_d);

    assign stallAny  = lwStall || brStall || sbStall;
    assign stall_f   = stallAny;
    assign stall_d   = stallAny;
    assign flush_e   = stallAny;
    assign issueLong = valid_d && long_op_d && !stallAny;

    // Saturating stall-cycle counter.
    always_ff @(posedge clock) begin
        if (reset)
            stall_count_q <= '0;
        else if (stallAny && (stall_count_q != '1))
            stall_count_q <= stall_count_q + COUNT_ONE;
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Self-checking bench for hazard_scoreboard. A reference model derived from
// the hazard rules predicts every output each cycle; the long unit is modelled
// by remembering the cycle number of the last issue and comparing its age
// against the latency.
module tb_hazard_scoreboard;

    localparam int RW   = 5;
    localparam int LAT  = 4;
    localparam int CNTW = 4;
    localparam int SAT  = (1 << CNTW) - 1;

    logic            clock = 1'b0;
    logic            reset;
    logic [RW-1:0]   rs_d, rt_d, wr_reg_d, rs_e, rt_e, wr_reg_e, wr_reg_m, wr_reg_w;
    logic            use_rs_d, use_rt_d, valid_d, branch_d, reg_write_d, long_op_d;
    logic            reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
    logic            stall_f, stall_d, flush_e, forward_a_d, forward_b_d;
    logic [1:0]      forward_a_e, forward_b_e;
    logic            long_busy, long_done;
    logic [RW-1:0]   long_reg;
    logic [CNTW-1:0] stall_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    bit mActive;
    int mIssueCycle;
    int mCycle;
    int mLongReg;
    int mStallCnt;

    // Expected values for the current cycle.
    bit         eStall, eBusy, eDone, eFwdAD, eFwdBD;
    logic [1:0] eFwdAE, eFwdBE;

    hazard_scoreboard #(
        .NREG     (32),
        .RW       (RW),
        .LONG_LAT (LAT),
        .CNT_W    (CNTW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .use_rs_d     (use_rs_d),
        .use_rt_d     (use_rt_d),
        .valid_d      (valid_d),
        .branch_d     (branch_d),
        .reg_write_d  (reg_write_d),
        .wr_reg_d     (wr_reg_d),
        .long_op_d    (long_op_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .wr_reg_e     (wr_reg_e),
        .wr_reg_m     (wr_reg_m),
        .wr_reg_w     (wr_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .forward_a_d  (forward_a_d),
        .forward_b_d  (forward_b_d),
        .long_busy    (long_busy),
        .long_done    (long_done),
        .long_reg     (long_reg),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    // Does decode read register x?
    function automatic bit readsD(int x);
        return (x != 0) && ((use_rs_d && rs_d == x) || (use_rt_d && rt_d == x));
    endfunction

    function automatic logic [1:0] fwdE(int src);
        if (reg_write_m && wr_reg_m != 0 && wr_reg_m == src) return 2'b10;
        if (reg_write_w && wr_reg_w != 0 && wr_reg_w == src) return 2'b01;
        return 2'b00;
    endfunction

    // Predict every combinational output from the present inputs and model state.
    task automatic computeExpected();
        int age;
        bit lw, br, sb;
        age    = mCycle - mIssueCycle;
        eBusy  = !reset && mActive && (age < LAT);
        eDone  = eBusy && (age == LAT - 1);
        eFwdAE = fwdE(rs_d == rs_d ? int'(rs_e) : 0);
        eFwdBE = fwdE(int'(rt_e));
        eFwdAD = reg_write_m && wr_reg_m != 0 && wr_reg_m == rs_d;
        eFwdBD = reg_write_m && wr_reg_m != 0 && wr_reg_m == rt_d;
        lw = mem_to_reg_e && readsD(int'(wr_reg_e));
        br = branch_d && ((reg_write_e && readsD(int'(wr_reg_e))) ||
                          (mem_to_reg_m && readsD(int'(wr_reg_m))));
        sb = valid_d && eBusy && (readsD(mLongReg) ||
                                  (reg_write_d && mLongReg != 0 && wr_reg_d == mLongReg) ||
                                  long_op_d);
        eStall = lw || br || sb;
    endtask

    task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, observed, expected, mCycle);
        end
    endtask

    task automatic checkOutput();
        computeExpected();
        checkVal("stall_f",     32'(stall_f),     32'(eStall));
        checkVal("stall_d",     32'(stall_d),     32'(eStall));
        checkVal("flush_e",     32'(flush_e),     32'(eStall));
        checkVal("forward_a_e", 32'(forward_a_e), 32'(eFwdAE));
        checkVal("forward_b_e", 32'(forward_b_e), 32'(eFwdBE));
        checkVal("forward_a_d", 32'(forward_a_d), 32'(eFwdAD));
        checkVal("forward_b_d", 32'(forward_b_d), 32'(eFwdBD));
        checkVal("long_busy",   32'(long_busy),   32'(eBusy));
        checkVal("long_done",   32'(long_done),   32'(eDone));
        checkVal("long_reg",    32'(long_reg),    32'(mLongReg));
        checkVal("stall_count", 32'(stall_count), 32'(mStallCnt));
    endtask

    task automatic clearInputs();
        {rs_d, rt_d, wr_reg_d, rs_e, rt_e, wr_reg_e, wr_reg_m, wr_reg_w} = '0;
        {use_rs_d, use_rt_d, valid_d, branch_d, reg_write_d, long_op_d} = '0;
        {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    endtask

    // Settle the inputs just driven and compare against the model.
    task automatic applyStimulus();
        #1;
        checkOutput();
    endtask

    // Take one rising edge and advance the model with the inputs seen there.
    task automatic advance();
        computeExpected();
        @(posedge clock);
        if (reset) begin
            mActive   = 1'b0;
            mLongReg  = 0;
            mStallCnt = 0;
        end else begin
            if (eStall && mStallCnt < SAT) mStallCnt++;
            if (valid_d && long_op_d && !eStall) begin
                mActive     = 1'b1;
                mIssueCycle = mCycle + 1;
                mLongReg    = int'(wr_reg_d);
            end
        end
        mCycle++;
        @(negedge clock);
    endtask

    task automatic issueLong(int dst);
        clearInputs();
        valid_d = 1; long_op_d = 1; reg_write_d = 1; wr_reg_d = RW'(dst);
        applyStimulus();
        checkVal("issue_no_stall", 32'(stall_d), 32'd0);
        advance();
    endtask

    initial begin
        mActive = 0; mIssueCycle = 0; mCycle = 0; mLongReg = 0; mStallCnt = 0;
        reset = 1'b1;
        clearInputs();
        advance();
        advance();
        reset = 1'b0;

        // After reset with all-zero inputs every output is zero.
        applyStimulus();
        checkVal("rst_stall",  32'(stall_d),     32'd0);
        checkVal("rst_busy",   32'(long_busy),   32'd0);
        checkVal("rst_count",  32'(stall_count), 32'd0);
        checkVal("rst_lreg",   32'(long_reg),    32'd0);
        advance();

        // E forwarding: M wins over W, W next, r0 never forwards.
        clearInputs();
        reg_write_m = 1; wr_reg_m = 5; reg_write_w = 1; wr_reg_w = 5; rs_e = 5; rt_e = 5;
        applyStimulus();
        checkVal("fwd_a_m", 32'(forward_a_e), 32'd2);
        checkVal("fwd_b_m", 32'(forward_b_e), 32'd2);
        advance();
        wr_reg_m = 0;
        applyStimulus();
        checkVal("fwd_a_w", 32'(forward_a_e), 32'd1);
        checkVal("fwd_b_w", 32'(forward_b_e), 32'd1);
        advance();
        wr_reg_w = 0; rs_e = 0; rt_e = 0; reg_write_e = 1;
        applyStimulus();
        checkVal("fwd_a_r0", 32'(forward_a_e), 32'd0);
        advance();

        // Load-use stall for one cycle, then the load moves on.
        clearInputs();
        mem_to_reg_e = 1; reg_write_e = 1; wr_reg_e = 8; rs_d = 8; use_rs_d = 1; valid_d = 1;
        applyStimulus();
        checkVal("lw_stall", 32'(stall_d), 32'd1);
        checkVal("lw_cnt0",  32'(stall_count), 32'd0);
        advance();
        clearInputs();
        rs_d = 8; use_rs_d = 1; valid_d = 1;
        applyStimulus();
        checkVal("lw_cnt1",  32'(stall_count), 32'd1);
        checkVal("lw_gone",  32'(stall_d), 32'd0);
        advance();
        mem_to_reg_e = 1; reg_write_e = 1; wr_reg_e = 8; use_rs_d = 0;
        applyStimulus();
        checkVal("lw_unused", 32'(stall_d), 32'd0);
        advance();

        // Branch against an ALU writer in E, then forwarded from M.
        clearInputs();
        branch_d = 1; valid_d = 1; rs_d = 3; use_rs_d = 1; reg_write_e = 1; wr_reg_e = 3;
        applyStimulus();
        checkVal("br_stall", 32'(stall_d), 32'd1);
        advance();
        reg_write_e = 0; wr_reg_e = 0; reg_write_m = 1; wr_reg_m = 3;
        applyStimulus();
        checkVal("br_fwd",   32'(forward_a_d), 32'd1);
        checkVal("br_go",    32'(stall_d), 32'd0);
        advance();

        // Long op to r9 and a dependent reader: four stall cycles.
        issueLong(9);
        clearInputs();
        valid_d = 1; rs_d = 9; use_rs_d = 1;
        for (int i = 0; i < LAT; i++) begin
            applyStimulus();
            checkVal("raw_stall", 32'(stall_d), 32'd1);
            checkVal("raw_done",  32'(long_done), 32'(i == LAT - 1));
            advance();
        end
        applyStimulus();
        checkVal("raw_leave", 32'(stall_d), 32'd0);
        checkVal("raw_idle",  32'(long_busy), 32'd0);
        advance();

        // Independent op passes; second long op and WAW on r9 wait.
        issueLong(9);
        clearInputs();
        valid_d = 1; rs_d = 4; use_rs_d = 1; reg_write_d = 1; wr_reg_d = 6;
        applyStimulus();
        checkVal("indep", 32'(stall_d), 32'd0);
        advance();
        clearInputs();
        valid_d = 1; long_op_d = 1; reg_write_d = 1; wr_reg_d = 7;
        applyStimulus();
        checkVal("struct", 32'(stall_d), 32'd1);
        advance();
        clearInputs();
        valid_d = 1; reg_write_d = 1; wr_reg_d = 9;
        applyStimulus();
        checkVal("waw", 32'(stall_d), 32'd1);
        advance();
        clearInputs();
        for (int i = 0; i < LAT; i++) begin
            applyStimulus();
            advance();
        end

        // Reset two cycles after issue abandons the long op.
        issueLong(12);
        clearInputs();
        applyStimulus();
        advance();
        reset = 1'b1;
        applyStimulus();
        advance();
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            applyStimulus();
            checkVal("abandon_busy", 32'(long_busy), 32'd0);
            checkVal("abandon_done", 32'(long_done), 32'd0);
            advance();
        end

        // Stall held for 20 cycles saturates the 4-bit counter.
        clearInputs();
        mem_to_reg_e = 1; wr_reg_e = 2; rt_d = 2; use_rt_d = 1; valid_d = 1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            advance();
        end
        applyStimulus();
        checkVal("saturate", 32'(stall_count), 32'd15);
        reset = 1'b1;
        advance();
        reset = 1'b0;

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            rs_d         = RW'($urandom_range(0, 3));
            rt_d         = RW'($urandom_range(0, 3));
            wr_reg_d     = RW'($urandom_range(0, 3));
            rs_e         = RW'($urandom_range(0, 3));
            rt_e         = RW'($urandom_range(0, 3));
            wr_reg_e     = RW'($urandom_range(0, 3));
            wr_reg_m     = RW'($urandom_range(0, 3));
            wr_reg_w     = RW'($urandom_range(0, 3));
            use_rs_d     = 1'($urandom_range(0, 1));
            use_rt_d     = 1'($urandom_range(0, 1));
            valid_d      = ($urandom_range(0, 3) != 0);
            branch_d     = ($urandom_range(0, 3) == 0);
            reg_write_d  = 1'($urandom_range(0, 1));
            long_op_d    = ($urandom_range(0, 2) == 0);
            reg_write_e  = 1'($urandom_range(0, 1));
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            mem_to_reg_e = ($urandom_range(0, 3) == 0);
            mem_to_reg_m = ($urandom_range(0, 3) == 0);
            applyStimulus();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
